// File: rtl/aes_dec_round_ctrl.sv
// Iterative round sequencer for the AES inverse cipher: accepts a ciphertext block, walks the
// round-key index from the initial AddRoundKey through the final round, then presents plaintext.
module aes_dec_round_ctrl #(
    parameter int Nr = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    output logic [RW-1:0] rk_idx,
    output logic [127:0]  st_q,
    input  logic [127:0]  first_res,
    input  logic [127:0]  mid_res,
    input  logic [127:0]  final_res,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic          busy,
    output logic [15:0]   blk_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } ctrlStateT;

    localparam logic [RW-1:0] LastRnd = RW'(Nr);

    ctrlStateT     state;
    logic [RW-1:0] rnd;
    logic [127:0]  stReg;
    logic [15:0]   blkCntReg;
    logic          outValidReg;
    logic          busyReg;

    // The ciphertext only reaches the state register through the datapath's first_res.
    logic unusedInData;
    assign unusedInData = ^in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rnd         <= '0;
            stReg       <= '0;
            blkCntReg   <= '0;
            outValidReg <= 1'b0;
            busyReg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && key_valid) begin
                        stReg   <= first_res;
                        rnd     <= RW'(1);
                        busyReg <= 1'b1;
                        state   <= ROUND;
                    end
                end
                // rnd is left at Nr on the final round so rk_idx reads Nr throughout DONE.
                ROUND: begin
                    if (rnd == LastRnd) begin
                        stReg       <= final_res;
                        outValidReg <= 1'b1;
                        state       <= DONE;
                    end else begin
                        stReg <= mid_res;
                        rnd   <= rnd + RW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        blkCntReg   <= blkCntReg + 16'd1;
                        rnd         <= '0;
                        outValidReg <= 1'b0;
                        busyReg     <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && key_valid;
    assign rk_idx    = rnd;
    assign st_q      = stReg;
    assign out_data  = stReg;
    assign out_valid = outValidReg;
    assign busy      = busyReg;
    assign blk_cnt   = blkCntReg;

endmodule
